// File: rtl/id_branch_ctrl_pkg.sv
// Shared decode definitions for the ID stage: opcodes, field positions, FSM states.
package id_pkg;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_JMP = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LD  = 6'h23;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned SRCA_MSB  = 25;
  localparam int unsigned SRCA_LSB  = 21;
  localparam int unsigned SRCB_MSB  = 20;
  localparam int unsigned SRCB_LSB  = 16;
  localparam int unsigned IMM16_MSB = 15;
  localparam int unsigned IMM26_MSB = 25;

  typedef enum logic {RUN, STALL} state_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/id_branch_ctrl_branch_resolve.sv
// Combinational branch condition and fetch-relative word offset for the ID instruction.
module branch_resolve
  import id_pkg::*;
(
  input  logic [31:0] idInstruction,
  input  logic [31:0] rs1Data,
  input  logic [31:0] rs2Data,
  input  logic        idValid,
  output logic        cond,
  output logic [31:0] brOffset
);

  logic        raw_cond;
  logic [31:0] imm;

  always_comb begin
    raw_cond = 1'b0;
    imm      = {{16{idInstruction[IMM16_MSB]}}, idInstruction[IMM16_MSB:0]};
    case (opcode_of(idInstruction))
      OP_JMP: begin
        raw_cond = 1'b1;
        imm      = {{6{idInstruction[IMM26_MSB]}}, idInstruction[IMM26_MSB:0]};
      end
      OP_BEQ:  raw_cond = (rs1Data == rs2Data);
      OP_BNE:  raw_cond = (rs1Data != rs2Data);
      default: raw_cond = 1'b0;
    endcase
    // Fetch already sits at branchPC + 4, hence the -1 word correction.
    brOffset = imm - 32'd1;
    cond     = idValid & raw_cond;
  end

endmodule

// File: rtl/id_branch_ctrl.sv
// IF/ID pipeline register with decode-stage branch resolution and load-use / memory freeze.
// Optional BRANCH_STATS_EN adds a taken-branch counter output (branchCount).
module id_branch_ctrl
  import id_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic        memStall,
  input  logic [31:0] rs1Data,
  input  logic [31:0] rs2Data,
  output logic        brTaken,
  output logic [31:0] brOffset,
  output logic        freeze,
  output logic [4:0]  rs1Addr,
  output logic [4:0]  rs2Addr,
  output logic        idValid,
  output logic [31:0] idPC,
  output logic [31:0] idInstruction
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] branchCount
`endif
);

  state_t     state;
  logic [1:0] stall_cnt;
  logic       cond;
  logic       hazard;
  logic [4:0] ld_rd;
  logic [5:0] in_op;

  branch_resolve u_branch_resolve (
    .idInstruction (idInstruction),
    .rs1Data       (rs1Data),
    .rs2Data       (rs2Data),
    .idValid       (idValid),
    .cond          (cond),
    .brOffset      (brOffset)
  );

  assign rs1Addr = idInstruction[SRCA_MSB:SRCA_LSB];
  assign rs2Addr = idInstruction[SRCB_MSB:SRCB_LSB];
  assign freeze  = memStall | (state == STALL);
  assign brTaken = cond & ~freeze;

  assign ld_rd  = idInstruction[SRCB_MSB:SRCB_LSB];
  assign in_op  = opcode_of(instruction);
  assign hazard = idValid && (opcode_of(idInstruction) == OP_LD) && (ld_rd != '0)
                  && (in_op != OP_NOP) && (in_op != OP_JMP)
                  && ((instruction[SRCA_MSB:SRCA_LSB] == ld_rd) ||
                      (instruction[SRCB_MSB:SRCB_LSB] == ld_rd));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= RUN;
      stall_cnt     <= '0;
      idValid       <= 1'b0;
      idPC          <= '0;
      idInstruction <= '0;
    end else if (!memStall) begin
      case (state)
        STALL: begin
          idValid       <= 1'b0;
          idInstruction <= '0;
          if (stall_cnt == '0) state <= RUN;
          else                 stall_cnt <= stall_cnt - 2'd1;
        end
        default: begin
          if (brTaken) begin
            // Squash the wrong-path instruction fetched behind the branch.
            idValid       <= 1'b0;
            idInstruction <= '0;
          end else if (hazard) begin
            state         <= STALL;
            stall_cnt     <= 2'(LOAD_STALL_CYCLES - 1);
            idValid       <= 1'b0;
            idInstruction <= '0;
          end else begin
            idValid       <= 1'b1;
            idPC          <= PC;
            idInstruction <= instruction;
          end
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn)        branchCount <= '0;
    else if (brTaken) branchCount <= branchCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Randomized bench for id_branch_ctrl against a behavioural model of the ID slot.
module tb_id_branch_ctrl;

  localparam int unsigned NSTALL = 2;
  localparam logic [5:0] T_NOP = 6'h00, T_JMP = 6'h02, T_BEQ = 6'h04,
                         T_BNE = 6'h05, T_LD = 6'h23, T_ADD = 6'h08;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] PC = '0, instruction = '0, rs1Data = '0, rs2Data = '0;
  logic        memStall = 1'b0;
  logic        brTaken, freeze, idValid;
  logic [31:0] brOffset, idPC, idInstruction;
  logic [4:0]  rs1Addr, rs2Addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] branchCount;
`endif

  id_branch_ctrl #(.LOAD_STALL_CYCLES(NSTALL)) dut (
    .clk(clk), .rstn(rstn), .PC(PC), .instruction(instruction), .memStall(memStall),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .brTaken(brTaken), .brOffset(brOffset),
    .freeze(freeze), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .idValid(idValid),
    .idPC(idPC), .idInstruction(idInstruction)
`ifdef BRANCH_STATS_EN
    , .branchCount(branchCount)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: contents of the ID slot plus how many frozen cycles remain.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_instr = '0, m_count = '0;
  int unsigned m_stall_left = 0;

  function automatic logic m_cond(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    case (ins[31:26])
      T_JMP:   return 1'b1;
      T_BEQ:   return a == b;
      T_BNE:   return a != b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_off(input logic [31:0] ins);
    longint imm;
    if (ins[31:26] == T_JMP)
      imm = ins[25] ? longint'(ins[25:0]) - 64'sd67108864 : longint'(ins[25:0]);
    else
      imm = ins[15] ? longint'(ins[15:0]) - 64'sd65536 : longint'(ins[15:0]);
    return 32'(imm - 1);
  endfunction

  function automatic logic m_hazard(input logic [31:0] id_ins, input logic id_v, input logic [31:0] ins);
    logic [4:0] rd;
    rd = id_ins[20:16];
    return id_v && id_ins[31:26] == T_LD && rd != 0 && ins[31:26] != T_NOP &&
           ins[31:26] != T_JMP && (ins[25:21] == rd || ins[20:16] == rd);
  endfunction

  function automatic logic exp_freeze();
    return memStall || (m_stall_left != 0);
  endfunction

  function automatic logic exp_taken();
    return m_valid && m_cond(m_instr, rs1Data, rs2Data) && !exp_freeze();
  endfunction

  always @(posedge clk) begin : model_update
    logic tk;
    tk = exp_taken();
    if (!rstn) begin
      m_valid = 1'b0; m_pc = '0; m_instr = '0; m_stall_left = 0; m_count = '0;
    end else if (memStall) begin
      // slot frozen
    end else if (m_stall_left > 0) begin
      m_valid = 1'b0; m_instr = '0; m_stall_left--;
    end else if (tk) begin
      m_valid = 1'b0; m_instr = '0; m_count++;
    end else if (m_hazard(m_instr, m_valid, instruction)) begin
      m_valid = 1'b0; m_instr = '0; m_stall_left = NSTALL;
    end else begin
      m_valid = 1'b1; m_pc = PC; m_instr = instruction;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("freeze", {31'b0, freeze}, {31'b0, exp_freeze()});
      check("brTaken", {31'b0, brTaken}, {31'b0, exp_taken()});
      check("brOffset", brOffset, m_off(m_instr));
      check("idValid", {31'b0, idValid}, {31'b0, m_valid});
      check("idInstruction", idInstruction, m_instr);
      check("rs_addrs", {22'b0, rs1Addr, rs2Addr}, {22'b0, m_instr[25:21], m_instr[20:16]});
      if (m_valid) check("idPC", idPC, m_pc);
`ifdef BRANCH_STATS_EN
      check("branchCount", branchCount, m_count);
`endif
    end
  end

  // One clock: edge, apply next inputs, stop at the following negedge for observation.
  task automatic cyc(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ms, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    rstn = r; PC = pc; instruction = ins; memStall = ms; rs1Data = a; rs2Data = b;
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] sa,
                                     input logic [4:0] sb, input logic [15:0] imm);
    return {op, sa, sb, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 5))
      0: op = T_NOP;
      1: op = T_JMP;
      2: op = T_BEQ;
      3: op = T_BNE;
      4: op = T_LD;
      default: op = T_ADD;
    endcase
    if (op == T_NOP) return '0;
    return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom()));
  endfunction

  initial begin : stim
    logic [31:0] beq_i, bne_i, ld_i, add_i, jmp_i;
    int unsigned fc;
    logic got;
    beq_i = mk(T_BEQ, 5'd1, 5'd2, 16'd3);
    bne_i = mk(T_BNE, 5'd1, 5'd2, 16'hFFFE);
    ld_i  = mk(T_LD, 5'd1, 5'd5, 16'd0);
    add_i = mk(T_ADD, 5'd5, 5'd3, 16'd0);
    jmp_i = {T_JMP, 26'h3FF_FFFF};

    // Reset held with a BEQ presented
    cyc(1'b0, 32'h100, beq_i, 1'b0, 32'd7, 32'd7);
    cyc(1'b0, 32'h100, beq_i, 1'b0, 32'd7, 32'd7);
    check("rst_idValid", {31'b0, idValid}, 32'd0);
    check("rst_brTaken", {31'b0, brTaken}, 32'd0);
    check("rst_freeze", {31'b0, freeze}, 32'd0);
    check("rst_idInstruction", idInstruction, 32'd0);
    check("rst_idPC", idPC, 32'd0);
    check("rst_brOffset", brOffset, 32'hFFFF_FFFF);

    // BEQ at 0x100, imm 3, equal operands
    cyc(1'b1, 32'h100, beq_i, 1'b0, 32'd7, 32'd7);
    cyc(1'b1, 32'h104, '0, 1'b0, 32'd7, 32'd7);
    check("beq_idPC", idPC, 32'h100);
    check("beq_taken", {31'b0, brTaken}, 32'd1);
    check("beq_offset", brOffset, 32'd2);
    cyc(1'b1, 32'h10C, mk(T_ADD, 5'd9, 5'd9, 16'd0), 1'b0, 32'd7, 32'd7);
    check("beq_squash", {31'b0, idValid}, 32'd0);
    check("beq_one_cycle", {31'b0, brTaken}, 32'd0);
    cyc(1'b1, 32'h110, '0, 1'b0, 32'd0, 32'd0);
    check("beq_target_pc", idPC, 32'h10C);
    check("beq_target_valid", {31'b0, idValid}, 32'd1);

    // BNE, imm -2
    cyc(1'b1, 32'h200, bne_i, 1'b0, 32'd1, 32'd1);
    cyc(1'b1, 32'h204, '0, 1'b0, 32'd1, 32'd1);
    check("bne_eq_taken", {31'b0, brTaken}, 32'd0);
    check("bne_offset", brOffset, 32'hFFFF_FFFD);
    rs2Data = 32'd2;
    #1;
    check("bne_ne_taken", {31'b0, brTaken}, 32'd1);

    // Load-use hazard on rd=5
    cyc(1'b1, 32'h2FC, '0, 1'b0, 32'd0, 32'd0);
    cyc(1'b1, 32'h300, ld_i, 1'b0, 32'd0, 32'd0);
    cyc(1'b1, 32'h304, add_i, 1'b0, 32'd0, 32'd0);
    check("ld_in_id_no_freeze", {31'b0, freeze}, 32'd0);
    fc = 0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'h304, add_i, 1'b0, 32'd0, 32'd0);
      if (freeze) fc++;
      if (idValid && idInstruction == add_i) begin
        got = 1'b1;
        break;
      end
    end
    check("ld_freeze_cycles", fc, NSTALL);
    check("ld_dep_captured", {31'b0, got}, 32'd1);

    // rd=0 load never stalls
    cyc(1'b1, 32'h400, mk(T_LD, 5'd1, 5'd0, 16'd0), 1'b0, 32'd0, 32'd0);
    cyc(1'b1, 32'h404, mk(T_ADD, 5'd0, 5'd0, 16'd0), 1'b0, 32'd0, 32'd0);
    check("ld_r0_no_freeze", {31'b0, freeze}, 32'd0);
    cyc(1'b1, 32'h408, '0, 1'b0, 32'd0, 32'd0);
    check("ld_r0_captured", idInstruction, mk(T_ADD, 5'd0, 5'd0, 16'd0));

    // JMP -1 held by memStall for 3 cycles
    cyc(1'b1, 32'h500, jmp_i, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h504, '0, 1'b1, 32'd0, 32'd0);
      check("ms_taken", {31'b0, brTaken}, 32'd0);
      check("ms_freeze", {31'b0, freeze}, 32'd1);
      check("ms_hold", idInstruction, jmp_i);
    end
    cyc(1'b1, 32'h504, '0, 1'b0, 32'd0, 32'd0);
    check("ms_release_taken", {31'b0, brTaken}, 32'd1);
    check("ms_release_offset", brOffset, 32'hFFFF_FFFE);

    // Random traffic, including occasional resets and memory stalls
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) != 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rand_instr(),
          $urandom_range(0, 4) == 0, 32'($urandom_range(0, 2)), 32'($urandom_range(0, 2)));
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_branch_ctrl.md
Name: id_branch_ctrl

Overview:
- Consumer end of the fetch interface. Captures the fetch stage's PC/instruction into the IF/ID pipeline register.
- Resolves branches in decode and drives brTaken/brOffset back to fetch.
- Generates freeze for load-use hazards and external memory stalls.
- One cycle of branch penalty; fetch computes its next PC as PC + 4 or PC + (brOffset << 2).

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted on a load-use hazard; legal range 1..3.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- PC  input  32  fetch-stage PC
- instruction  input  32  fetch-stage instruction
- memStall  input  1  downstream memory stall
- rs1Data  input  32  register-file data for rs1Addr
- rs2Data  input  32  register-file data for rs2Addr
- brTaken  output  1  redirect fetch
- brOffset  output  32  word offset relative to the fetch PC
- freeze  output  1  hold the fetch PC register
- rs1Addr  output  5  idInstruction[25:21]
- rs2Addr  output  5  idInstruction[20:16]
- idValid  output  1  ID slot holds a real instruction
- idPC  output  32  PC of the ID instruction
- idInstruction  output  32  ID instruction (0 = NOP)

Behaviour:
- Clock and reset: single clock clk; rstn is synchronous, active-low, sampled at the rising edge.
- Reset values: idValid=0, idPC=0, idInstruction=0, state=RUN, stall counter=0.
  - Consequences: brTaken=0, freeze=memStall, brOffset=32'hFFFF_FFFF (NOP).
  - Reset mid-stall or mid-branch abandons the operation.
- Encoding:
  - opcode [31:26]: NOP=00, JMP=02, BEQ=04, BNE=05, LD=23.
  - srcA [25:21], srcB [20:16], imm16 [15:0], imm26 [25:0].
  - LD: base=srcA, rd=srcB.
- Branch resolution (combinational):
  - cond: BEQ when rs1Data==rs2Data; BNE when they differ; JMP always.
  - brTaken = idValid & cond & ~freeze.
  - brOffset = sext(imm) - 1, 32-bit modulo 2^32. Fetch already holds branch PC + 4, so the target is branchPC + 4*sext(imm).
- FSM states: RUN and STALL.
- freeze = memStall | (state==STALL).
- RUN:
  - Hazard condition:
    - idValid and the ID opcode is LD with rd != 0;
    - the incoming opcode is neither NOP nor JMP;
    - incoming srcA==rd or srcB==rd.
  - On hazard: go to STALL, counter=LOAD_STALL_CYCLES-1, load a bubble into ID (idValid=0, idInstruction=0).
  - Otherwise capture PC/instruction with idValid=1.
- STALL:
  - freeze=1 and a bubble is loaded each cycle.
  - Counter==0 -> RUN; else decrement.
  - Fetch holds, so the dependent instruction is captured on the first RUN edge.
- Taken branch: at the edge where brTaken=1, ID loads a bubble (squashes the wrong-path PC+4 instruction). brTaken is therefore high for exactly one cycle per branch.
- memStall (highest priority):
  - ID register, state and counter all hold.
  - brTaken is suppressed; a pending branch resolves the cycle after memStall drops.
- Hazard and taken branch cannot coincide: ID holds either an LD or a branch, never both.
- Back-to-back taken branches are impossible: the slot after a taken branch is always a bubble.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds output port branchCount (32 bits), incremented on every cycle with brTaken=1. It wraps at 2^32 and clears on reset; memStall does not affect counting.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package id_pkg:
  - opcode constants: OP_NOP, OP_JMP, OP_BEQ, OP_BNE, OP_LD;
  - field-position localparams;
  - state enum typedef {RUN, STALL}.
- Sub-module branch_resolve: combinational; inputs idInstruction, rs1Data, rs2Data, idValid; outputs cond and brOffset. Reused later by the EX-stage forwarding path.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with instruction=BEQ -> idValid=0, brTaken=0, freeze=0, idInstruction=0. On release, the first instruction is captured the next edge.
- BEQ in ID, PC=0x100, imm16=3, rs1Data=rs2Data=7:
  - expect brTaken=1 and brOffset=2 for one cycle;
  - next cycle idValid=0;
  - following cycle idPC=0x10C.
- BNE, imm16=-2 (0xFFFE), rs1Data=1, rs2Data=1 -> brTaken=0 and brOffset=0xFFFF_FFFD. Repeat with rs2Data=2 -> brTaken=1.
- LD rd=5 in ID, incoming ADD with srcA=5, LOAD_STALL_CYCLES=2:
  - freeze=1 for exactly 2 cycles, ID shows 2 bubbles;
  - then the ADD is captured with idValid=1.
  - rd=0 variant: no freeze.
- memStall=1 for 3 cycles with JMP imm26=-1 in ID:
  - brTaken=0, freeze=1, ID unchanged;
  - the cycle after release, brTaken=1 with brOffset=0xFFFF_FFFE.
- With BRANCH_STATS_EN: 4 taken and 2 not-taken branches -> branchCount=4. Reset asserted mid-sequence -> branchCount=0 and state=RUN.
